cordic_uart_framer: RTL

//  Sits between the CORDIC result stage and the 6-byte UART transmitter.

---
 rtl/cordic_uart_framer.sv | 112 +++++++++++
 1 files changed

// File: rtl/cordic_uart_framer.sv
// CORDIC result framer: buffers (cos, sin) pairs and feeds 48-bit frames
// {HEADER, seq, cos, sin} to a 6-byte UART transmitter, one frame in flight.
module cordic_uart_framer #(
  parameter int          FIFO_DEPTH     = 4,
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          res_valid,
  output logic                          res_ready,
  input  logic [15:0]                   cos_in,
  input  logic [15:0]                   sin_in,
  output logic                          tx_start,
  output logic [47:0]                   tx_data,
  input  logic                          trans_done,
  input  logic                          err_clr,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          timeout_err
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int CW    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] wait_cnt;
  logic [7:0]    seq;
  logic          full;
  logic          push;
  logic          load;
  logic          to_hit;

  assign full      = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign res_ready = ~full;
  assign push      = res_valid & ~full;
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    to_hit   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (fifo_count != '0) begin
          load     = 1'b1;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (trans_done) begin
          state_nx = S_IDLE;
        end else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          to_hit   = 1'b1;
          state_nx = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cos_in, sin_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      seq         <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      tx_start <= load;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (load) rd_ptr <= rd_ptr + AW'(1);
      case ({push, load})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (load) begin
        tx_data  <= {HEADER, seq, mem[rd_ptr]};
        seq      <= seq + 8'd1;
        wait_cnt <= '0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      if (to_hit)       timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule
